piso_tx32: RTL and testbench
============================

// Module: piso_tx32
// PURPOSE
//  - Parallel-in/serial-out transmitter; the send end paired with the 32-bit D-FF register/receive path.
//  - Accepts a WIDTH-bit word via valid/ready handshake, then shifts it out one bit per enabled cycle.
//  - Sits between the register datapath and a serial link; ser_en paces bits (baud tick or 1'b1).
// PARAMETERS
//  WIDTH       32   word width; bits numbered [0:WIDTH-1], bit 0 sent first
//  CNT_W       5    bit-counter width; must satisfy 2**CNT_W >= WIDTH
//  IDLE_LEVEL  1'b0 ser_out level while not transmitting
// PORTS
//  clk        in   1        rising-edge clock, single clock domain
//  res        in   1        synchronous, active-low reset (sampled on rising edge of clk)
//  data_in    in   [0:31]   parallel word to transmit
//  in_valid   in   1        data_in is valid
//  in_ready   out  1        block can accept a word this cycle
//  ser_en     in   1        advance one bit this cycle
//  ser_out    out  1        serial data
//  ser_valid  out  1        ser_out carries a frame bit
//  ser_last   out  1        ser_out carries bit WIDTH-1 of the frame
//  busy       out  1        frame in progress (== ser_valid)
// BEHAVIOUR
//  - Reset (res==0 at edge): state=IDLE, shreg=0, cnt=0; ser_out=IDLE_LEVEL, ser_valid=0,
//    ser_last=0, busy=0. in_ready=0 combinationally while res==0. Reset mid-frame aborts the frame; no partial bits resume.
//  - States: IDLE, SHIFT. Encoding 1 bit.
//  - in_ready = res & (IDLE | (SHIFT & cnt==WIDTH-1 & ser_en)).
//  - Accept = in_valid & in_ready at edge: shreg<=data_in, cnt<=0, state<=SHIFT.
//  - Latency: word accepted at edge N -> bit 0 on ser_out from after edge N; no gap cycles.
//  - SHIFT: ser_out=shreg[0], ser_valid=1. On edge with ser_en=1: shreg<=shreg<<1 (toward index 0, zero fill),
//    cnt<=cnt+1. ser_en=0: hold all state (bit held on ser_out).
//  - ser_last=1 iff SHIFT & cnt==WIDTH-1. At that edge with ser_en=1: accept if in_valid (back-to-back,
//    bit 0 of next word follows immediately, cnt wraps to 0), else state<=IDLE.
//  - in_valid in SHIFT before the last bit is ignored (in_ready=0); data_in not sampled.
//  - Outputs derive only from registers (ser_out/ser_valid/ser_last/busy glitch-free); in_ready is combinational.
//  - cnt never exceeds WIDTH-1; no wrap other than the defined frame wrap.
// STRUCTURE
//  - Shared include (piso_defs.vh): `define TX_IDLE 1'b0, `define TX_SHIFT 1'b1, default WIDTH/CNT_W.
//  - One sub-module: tx_bit_cnt (CNT_W-bit counter, sync active-low clear, load-zero, enable,
//    terminal-count flag at WIDTH-1). Shift register and FSM stay in piso_tx32.
// TESTING
//  1. Hold res=0 two cycles, in_valid=1 -> ser_valid=0, ser_out=0, in_ready=0, no accept.
//  2. ser_en=1, send 32'hA5A5_0001 -> ser_out bits 1,0,1,0,0,1,0,1,... last bit 1; ser_last only on 32nd bit cycle.
//  3. Back-to-back 32'hFFFF_FFFF then 32'h0000_0000, in_valid held -> 64 contiguous ser_valid cycles, no gap.
//  4. ser_en toggled 1,0,1,0 during 32'h8000_0000 -> each bit held two cycles; frame spans 64 cycles.
//  5. res=0 at bit 10 of 32'hDEAD_BEEF -> next cycle IDLE, ser_valid=0; new word restarts at bit 0.
//  6. in_valid=1 with 32'h1234_5678 at bit 5 of active frame -> ignored; current frame unchanged.

Source files
------------

// File: rtl/piso_tx32_pkg.sv
// Shared constants for the 32-bit parallel-in/serial-out transmitter.
// State codes are 1-bit constants so the FSM encoding matches older RTL.
package piso_tx32_pkg;

    localparam int PISO_WIDTH = 32;
    localparam int PISO_CNT_W = 5;
    localparam logic PISO_IDLE_LEVEL = 1'b0;

    localparam logic [0:0] TX_IDLE  = 1'b0;
    localparam logic [0:0] TX_SHIFT = 1'b1;

endpackage

// File: rtl/piso_tx32_if.sv
// Word handshake plus serial link signals of the transmitter.
// Frame bits are numbered [0:WIDTH-1]; bit 0 is sent first.
interface piso_tx32_if #(
    parameter int WIDTH = 32
);
    logic [0:WIDTH-1] data_in;
    logic             in_valid;
    logic             in_ready;
    logic             ser_en;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             busy;

    modport master (
        output data_in, in_valid, ser_en,
        input  in_ready, ser_out, ser_valid, ser_last, busy
    );

    modport slave (
        input  data_in, in_valid, ser_en,
        output in_ready, ser_out, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/piso_tx32_tx_bit_cnt.sv
// Frame bit counter: sync active-low clear, load-zero, enable, and a
// terminal-count flag raised while the last frame bit is on the line.
module tx_bit_cnt #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic clk_i,
    input  logic clr_b_i,
    input  logic load0_i,
    input  logic en_i,
    output logic tc_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load0_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clr_b_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/piso_tx32.sv
// Parallel-in/serial-out transmitter: takes a word on a valid/ready
// handshake and shifts it out LSB-index first, one bit per ser_en cycle.
module piso_tx32
    import piso_tx32_pkg::*;
#(
    parameter int   WIDTH      = PISO_WIDTH,
    parameter int   CNT_W      = PISO_CNT_W,
    parameter logic IDLE_LEVEL = PISO_IDLE_LEVEL
) (
    input  logic          clk_i,
    input  logic          res_i,
    piso_tx32_if.slave    tx
);
    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [0:WIDTH-1] shreg_q;
    logic [0:WIDTH-1] shreg_d;
    logic             tc;
    logic             shifting;
    logic             frame_end;
    logic             ready;
    logic             accept;

    assign shifting  = (state_q == TX_SHIFT);
    assign frame_end = shifting & tc & tx.ser_en;
    assign ready     = res_i & (~shifting | frame_end);
    assign accept    = tx.in_valid & ready;

    // Counter returns to zero on every frame end so it never exceeds WIDTH-1.
    tx_bit_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_cnt (
        .clk_i   (clk_i),
        .clr_b_i (res_i),
        .load0_i (accept | frame_end),
        .en_i    (shifting & tx.ser_en),
        .tc_o    (tc)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        if (accept) begin
            state_d = TX_SHIFT;
            shreg_d = tx.data_in;
        end else if (shifting && tx.ser_en) begin
            shreg_d = shreg_q << 1;
            if (tc) begin
                state_d = TX_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!res_i) begin
            state_q <= TX_IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    assign tx.in_ready  = ready;
    assign tx.ser_out   = shifting ? shreg_q[0] : IDLE_LEVEL;
    assign tx.ser_valid = shifting;
    assign tx.ser_last  = shifting & tc;
    assign tx.busy      = shifting;
endmodule

// File: tb/tb_piso_tx32.sv
// Self-checking bench for piso_tx32: directed scenarios plus random traffic,
// compared every cycle against a queue-of-pending-bits reference model.
module tb_piso_tx32;

    logic clk;
    logic res;

    piso_tx32_if #(.WIDTH(32)) tx ();

    piso_tx32 u_dut (
        .clk_i (clk),
        .res_i (res),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    logic model_q[$];
    logic [31:0] obs;
    int   vcnt;
    int   lastcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check outputs against the model, advance model.
    task automatic step(input logic r, input logic v, input logic [31:0] d, input logic en);
        logic m_ready;
        int   sz;
        res         = r;
        tx.in_valid = v;
        tx.data_in  = d;
        tx.ser_en   = en;
        #1;
        sz      = model_q.size();
        m_ready = r && (sz == 0 || (sz == 1 && en));
        chk("in_ready",  {31'd0, tx.in_ready},  {31'd0, m_ready});
        chk("ser_valid", {31'd0, tx.ser_valid}, {31'd0, (sz > 0)});
        chk("busy",      {31'd0, tx.busy},      {31'd0, (sz > 0)});
        chk("ser_last",  {31'd0, tx.ser_last},  {31'd0, (sz == 1)});
        chk("ser_out",   {31'd0, tx.ser_out},   {31'd0, (sz > 0) ? model_q[0] : 1'b0});
        if (tx.ser_valid) vcnt++;
        if (tx.ser_last)  lastcnt++;
        if (tx.ser_valid && en) obs = {obs[30:0], tx.ser_out};
        @(posedge clk);
        if (!r) begin
            model_q.delete();
        end else begin
            if (en && sz > 0) void'(model_q.pop_front());
            if (v && m_ready)
                for (int i = 0; i < 32; i++) model_q.push_back(d[31-i]);
        end
        @(negedge clk);
    endtask

    // Run with in_valid low until the model says the line is idle (bounded).
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (model_q.size() > 0 && n < 200) begin
            step(1'b1, 1'b0, $urandom, 1'b1);
            n++;
        end
        chk(tag, {31'd0, (n < 200)}, 32'd1);
    endtask

    initial begin
        logic [31:0] w;
        res         = 1'b0;
        tx.in_valid = 1'b0;
        tx.data_in  = '0;
        tx.ser_en   = 1'b0;
        obs = '0; vcnt = 0; lastcnt = 0;
        @(posedge clk);
        @(negedge clk);

        // reset held with valid asserted: nothing accepted
        step(1'b0, 1'b1, 32'hCAFE_0001, 1'b1);
        step(1'b0, 1'b1, 32'hCAFE_0002, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("rst_no_accept", {31'd0, tx.ser_valid}, 32'd0);

        // single frame, bit order
        obs = '0; vcnt = 0; lastcnt = 0;
        step(1'b1, 1'b1, 32'hA5A5_0001, 1'b1);
        drain("a5_drain");
        chk("a5_bits", obs, 32'hA5A5_0001);
        chk("a5_last_cnt", lastcnt, 32'd1);
        chk("a5_valid_cnt", vcnt, 32'd32);

        // back-to-back frames with valid held
        obs = '0; vcnt = 0;
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 32'h0000_0000, 1'b1);
        drain("b2b_drain");
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("b2b_valid_cnt", vcnt, 32'd64);

        // ser_en toggling: each bit held two cycles
        obs = '0; vcnt = 0;
        step(1'b1, 1'b1, 32'h8000_0000, 1'b1);
        for (int i = 0; i < 200 && model_q.size() > 0; i++)
            step(1'b1, 1'b0, 32'h0, (i % 2) == 1);
        chk("en_toggle_span", vcnt, 32'd64);
        chk("en_toggle_bits", obs, 32'h8000_0000);

        // reset mid-frame, then a fresh word from bit 0
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("abort_idle", {31'd0, tx.ser_valid}, 32'd0);
        obs = '0;
        w = $urandom;
        step(1'b1, 1'b1, w, 1'b1);
        drain("restart_drain");
        chk("restart_bits", obs, w);

        // valid mid-frame is ignored
        obs = '0;
        w = $urandom;
        step(1'b1, 1'b1, w, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h1234_5678, 1'b1);
        drain("ignore_drain");
        chk("ignore_bits", obs, w);

        // random traffic
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 60) != 0), ($urandom_range(0, 2) != 0),
                 $urandom, ($urandom_range(0, 3) != 0));
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
